// File: rtl/fib_sweep_pkg.sv
// Shared types for the Fibonacci sweep sequencer.
// Sweep FSM states and record-width helper.
package fib_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CLR,
    WAIT_DONE,
    STORE,
    FINISH
  } state_t;

  function automatic int rec_bits(
    input int n_w,
    input int r_w
  );
    return n_w + r_w + 1;
  endfunction

endpackage

// File: rtl/fib_sweep_fifo.sv
// First-word-fall-through result FIFO with count-based full/empty.
// A pop in the same cycle never frees a slot for that cycle's push.
module fib_sweep_fifo
  import fib_sweep_pkg::*;
#(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr;
  logic [AW-1:0]    rd;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end

endmodule

// File: rtl/fib_sweep.sv
// Sweeps the Fibonacci core over [n_start, n_end] and buffers
// each {n, result, overflow} record for a valid/ready consumer.
module fib_sweep
  import fib_sweep_pkg::*;
#(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 32,
  parameter int DEPTH        = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [INPUT_WIDTH-1:0]  n_start,
  input  logic [INPUT_WIDTH-1:0]  n_end,
  output logic                    busy,
  output logic                    sweep_done,
  output logic                    timeout_err,
  output logic                    fib_go,
  output logic [INPUT_WIDTH-1:0]  fib_n,
  input  logic [OUTPUT_WIDTH-1:0] fib_result,
  input  logic                    fib_overflow,
  input  logic                    fib_done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INPUT_WIDTH-1:0]  out_n,
  output logic [OUTPUT_WIDTH-1:0] out_result,
  output logic                    out_overflow
);

  localparam int RW = rec_bits(INPUT_WIDTH, OUTPUT_WIDTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [INPUT_WIDTH-1:0]  n;
    logic [OUTPUT_WIDTH-1:0] result;
    logic                    overflow;
  } rec_t;

  state_t               state;
  logic [INPUT_WIDTH:0] n_cur;
  logic [INPUT_WIDTH:0] n_last;
  logic [TW-1:0]        tcnt;
  logic                 tmo_hit;
  rec_t                 wr_rec;
  rec_t                 rd_rec;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  assign fib_go  = (state == ISSUE);
  assign fib_n   = n_cur[INPUT_WIDTH-1:0];
  assign tmo_hit = (tcnt == TW'(TIMEOUT - 1));
  assign push    = (state == STORE) && !full;
  assign pop     = out_valid && out_ready;
  assign wr_rec  = {fib_n, fib_result, fib_overflow};

  assign out_valid    = !empty;
  assign out_n        = rd_rec.n;
  assign out_result   = rd_rec.result;
  assign out_overflow = rd_rec.overflow;

  fib_sweep_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wr_rec),
    .dout  (rd_rec),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      n_cur       <= '0;
      n_last      <= '0;
      tcnt        <= '0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            n_cur       <= {1'b0, n_start};
            n_last      <= {1'b0, n_end};
            busy        <= 1'b1;
            sweep_done  <= 1'b0;
            timeout_err <= 1'b0;
            state       <= (n_start <= n_end) ? ISSUE : FINISH;
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= FINISH;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (!fib_done) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (fib_done) begin
            state <= STORE;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= FINISH;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        STORE: begin
          // wide counter lets n_end = all-ones finish without wrapping
          if (!full) begin
            if (n_cur == n_last) begin
              state <= FINISH;
            end else begin
              n_cur <= n_cur + 1'b1;
              state <= ISSUE;
            end
          end
        end
        FINISH: begin
          sweep_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_sweep.sv
// Directed bench for fib_sweep driving a behavioural Fibonacci core.
// Table vectors for record values plus hand sequences for corner cases.
module tb_fib_sweep;

  localparam int IW    = 6;
  localparam int OW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int LAT   = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic [IW-1:0] n_start;
  logic [IW-1:0] n_end;
  logic          busy;
  logic          sweep_done;
  logic          timeout_err;
  logic          fib_go;
  logic [IW-1:0] fib_n;
  logic [OW-1:0] fib_result;
  logic          fib_overflow;
  logic          fib_done;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_n;
  logic [OW-1:0] out_result;
  logic          out_overflow;

  fib_sweep #(
    .INPUT_WIDTH  (IW),
    .OUTPUT_WIDTH (OW),
    .DEPTH        (DEPTH),
    .TIMEOUT      (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .n_start      (n_start),
    .n_end        (n_end),
    .busy         (busy),
    .sweep_done   (sweep_done),
    .timeout_err  (timeout_err),
    .fib_go       (fib_go),
    .fib_n        (fib_n),
    .fib_result   (fib_result),
    .fib_overflow (fib_overflow),
    .fib_done     (fib_done),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_n        (out_n),
    .out_result   (out_result),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // F(0)=F(1)=0, F(2)=1, F(k)=F(k-1)+F(k-2)
  function automatic logic [63:0] fib(input int k);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    a = 64'd0;
    b = 64'd1;
    if (k == 0) return 64'd0;
    for (int i = 1; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  logic          hang;
  int            ccnt;
  logic [IW-1:0] cn;

  always @(posedge clk) begin
    if (rst) begin
      fib_done     <= 1'b0;
      fib_result   <= '0;
      fib_overflow <= 1'b0;
      ccnt         <= 0;
      cn           <= '0;
    end else if (fib_go) begin
      fib_done <= 1'b0;
      ccnt     <= LAT;
      cn       <= fib_n;
    end else if (ccnt != 0) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1 && !hang) begin
        fib_done     <= 1'b1;
        fib_result   <= OW'(fib(int'(cn)));
        fib_overflow <= ((fib(int'(cn)) >> OW) != 64'd0);
      end
    end
  end

  typedef struct {
    logic [IW-1:0] n;
    logic [OW-1:0] res;
    logic          ov;
  } vec_t;

  vec_t tbl[$];
  vec_t got[$];
  int   go_cnt = 0;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      got.push_back('{out_n, out_result, out_overflow});
    if (!rst && fib_go) go_cnt++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [IW-1:0] n, input logic [OW-1:0] r,
                     input logic o);
    tbl.push_back('{n, r, o});
  endtask

  task automatic start_sweep(input logic [IW-1:0] a,
                             input logic [IW-1:0] b);
    n_start = a;
    n_end   = b;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int c;
    c = 0;
    while (!sweep_done && c < budget) begin
      step();
      c++;
    end
    chk(name, 64'(sweep_done), 64'd1);
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    out_ready = 1'b1;
    while (out_valid && c < 100) begin
      step();
      c++;
    end
    chk(name, 64'(out_valid), 64'd0);
  endtask

  task automatic cmp_tbl(input int base, input int first, input int cnt,
                         input string name);
    chk({name, "_count"}, 64'(got.size() - base), 64'(cnt));
    for (int i = 0; i < cnt; i++) begin
      chk($sformatf("%s_n%0d", name, i),
          64'(got[base+i].n), 64'(tbl[first+i].n));
      chk($sformatf("%s_res%0d", name, i),
          64'(got[base+i].res), 64'(tbl[first+i].res));
      chk($sformatf("%s_ov%0d", name, i),
          64'(got[base+i].ov), 64'(tbl[first+i].ov));
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_sweep_done"}, 64'(sweep_done), 64'd0);
    chk({name, "_timeout_err"}, 64'(timeout_err), 64'd0);
    chk({name, "_fib_go"}, 64'(fib_go), 64'd0);
    chk({name, "_fib_n"}, 64'(fib_n), 64'd0);
    chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_out_n"}, 64'(out_n), 64'd0);
    chk({name, "_out_result"}, 64'(out_result), 64'd0);
    chk({name, "_out_overflow"}, 64'(out_overflow), 64'd0);
  endtask

  initial begin
    int base;
    int g0;
    int cyc;
    int te;

    rst       = 1'b1;
    start     = 1'b0;
    n_start   = '0;
    n_end     = '0;
    out_ready = 1'b1;
    hang      = 1'b0;

    // sweep 0..6
    add(0, 32'd0, 0); add(1, 32'd0, 0); add(2, 32'd1, 0);
    add(3, 32'd1, 0); add(4, 32'd2, 0); add(5, 32'd3, 0);
    add(6, 32'd5, 0);
    // sweep 48..50, wraps mod 2^32 from n=49
    add(48, 32'd2971215073, 0);
    add(49, 32'd512559680, 1);
    add(50, 32'd3483774753, 1);
    // sweep 2..9
    add(2, 32'd1, 0); add(3, 32'd1, 0); add(4, 32'd2, 0);
    add(5, 32'd3, 0); add(6, 32'd5, 0); add(7, 32'd8, 0);
    add(8, 32'd13, 0); add(9, 32'd21, 0);

    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    base = got.size();
    g0   = go_cnt;
    start_sweep(0, 6);
    chk("go_latency", 64'(fib_go), 64'd1);
    chk("busy_set", 64'(busy), 64'd1);
    wait_done(200, "s06_done");
    drain("s06_drain");
    cmp_tbl(base, 0, 7, "s06");
    chk("s06_busy_clr", 64'(busy), 64'd0);
    chk("s06_gos", 64'(go_cnt - g0), 64'd7);
    chk("s06_tmo", 64'(timeout_err), 64'd0);

    base = got.size();
    start_sweep(48, 50);
    wait_done(200, "s48_done");
    drain("s48_drain");
    cmp_tbl(base, 7, 3, "s48");

    base = got.size();
    g0   = go_cnt;
    out_ready = 1'b0;
    start_sweep(2, 9);
    repeat (60) step();
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_done", 64'(sweep_done), 64'd0);
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_gos", 64'(go_cnt - g0), 64'd5);
    chk("stall_head_n", 64'(out_n), 64'd2);
    repeat (5) step();
    chk("stall_hold_n", 64'(out_n), 64'd2);
    chk("stall_hold_res", 64'(out_result), 64'd1);
    chk("stall_busy2", 64'(busy), 64'd1);
    out_ready = 1'b1;
    wait_done(200, "s29_done");
    drain("s29_drain");
    cmp_tbl(base, 10, 8, "s29");

    base = got.size();
    g0   = go_cnt;
    start_sweep(5, 3);
    wait_done(2, "empty_done");
    chk("empty_gos", 64'(go_cnt - g0), 64'd0);
    chk("empty_valid", 64'(out_valid), 64'd0);
    chk("empty_busy", 64'(busy), 64'd0);
    chk("empty_recs", 64'(got.size() - base), 64'd0);

    base = got.size();
    g0   = go_cnt;
    start_sweep(60, 63);
    repeat (4) step();
    n_start = 0;
    n_end   = 1;
    start   = 1'b1;
    step();
    start   = 1'b0;
    wait_done(300, "s60_done");
    drain("s60_drain");
    chk("s60_count", 64'(got.size() - base), 64'd4);
    chk("s60_gos", 64'(go_cnt - g0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s60_n%0d", i), 64'(got[base+i].n), 64'(60 + i));
      chk($sformatf("s60_res%0d", i), 64'(got[base+i].res),
          64'(OW'(fib(60 + i))));
      chk($sformatf("s60_ov%0d", i), 64'(got[base+i].ov), 64'd1);
    end

    hang = 1'b1;
    base = got.size();
    g0   = go_cnt;
    start_sweep(10, 12);
    cyc = 1;
    te  = 0;
    while (!sweep_done && cyc < 40) begin
      step();
      cyc++;
      if (timeout_err && te == 0) te = cyc;
    end
    chk("tmo_err_at", 64'(te), 64'd18);
    chk("tmo_done_at", 64'(cyc), 64'd19);
    chk("tmo_err", 64'(timeout_err), 64'd1);
    chk("tmo_done", 64'(sweep_done), 64'd1);
    chk("tmo_gos", 64'(go_cnt - g0), 64'd1);
    chk("tmo_recs", 64'(got.size() - base), 64'd0);
    hang = 1'b0;

    out_ready = 1'b0;
    start_sweep(0, 6);
    repeat (20) step();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    chk_all_zero("midrst");
    rst = 1'b0;
    step();
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
